// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM state type, SPI mode
// constants and the minimum local-clock to sclk frequency ratio.
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   // Mode 0: sclk idles low, data sampled on the rising edge and
   // shifted out on the falling edge.
   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;

   // clk must run at least this many times faster than sclk so that every
   // synchronized sclk edge is seen and acted upon before the next one.
   localparam int MIN_CLK_RATIO = 4;

endpackage : spi_pkg

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, followed by a
// single-cycle rise/fall pulse generator working on the synchronized level.
module sync_edge_det #(
   parameter int   STAGES  = 2,    // at least 2 flops in the chain
   parameter logic RST_VAL = 1'b0  // idle level of the input
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   // Next values: shift the input into the chain, keep a copy of the last stage.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      prev_d = sync_q[STAGES-1];
   end

   // Synchronizer and edge-detect registers, preset to the line's idle level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge
         // value; blocking here would collapse the chain into one stage.
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_out = sync_q[STAGES-1];
   assign rise     =  sync_q[STAGES-1] & ~prev_q;
   assign fall     = ~sync_q[STAGES-1] &  prev_q;

endmodule : sync_edge_det

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder. sclk, cs_n and mosi are oversampled in the clk
// domain; received words appear on rx_data with a one-cycle rx_valid, and
// the word to send is preloaded through a single-entry tx buffer.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              tx_underrun
);

   localparam int   CNT_W          = $clog2(DATA_W + 1);
   localparam logic SAMPLE_ON_RISE = (CPOL == CPHA);

   // Synchronized edge pulses; levels are not needed beyond edge detection.
   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic cs_rise, cs_fall, cs_level_unused;

   sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
      .clk      (clk),
      .reset    (reset),
      .din      (sclk),
      .sync_out (sclk_level_unused),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk      (clk),
      .reset    (reset),
      .din      (cs_n),
      .sync_out (cs_level_unused),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   // mosi has the same depth as sclk so a sample edge sees the matching bit.
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   mosi_s;
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   logic sample_edge, shift_edge;
   assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
   assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

   spi_state_e        state_q, state_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              tx_ready_q, tx_ready_d;
   logic              rx_valid_q, rx_valid_d;
   logic              underrun_q, underrun_d;
   logic              wb_pending_q, wb_pending_d;
   logic              word_load;

   // State register plus all datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         mosi_sync_q  <= '0;
         rx_shift_q   <= '0;
         tx_shift_q   <= '0;
         tx_buf_q     <= '0;
         rx_data_q    <= '0;
         bit_cnt_q    <= '0;
         tx_ready_q   <= 1'b1;
         rx_valid_q   <= 1'b0;
         underrun_q   <= 1'b0;
         wb_pending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mosi_sync_q  <= mosi_sync_d;
         rx_shift_q   <= rx_shift_d;
         tx_shift_q   <= tx_shift_d;
         tx_buf_q     <= tx_buf_d;
         rx_data_q    <= rx_data_d;
         bit_cnt_q    <= bit_cnt_d;
         tx_ready_q   <= tx_ready_d;
         rx_valid_q   <= rx_valid_d;
         underrun_q   <= underrun_d;
         wb_pending_q <= wb_pending_d;
      end
   end

   // Next state: chip-select edges move between IDLE and ACTIVE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall) state_d = ACTIVE;
         ACTIVE:  if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A word is loaded into the tx shifter on entry to ACTIVE and on the first
   // shift edge after a completed word.
   assign word_load = ((state_q == IDLE) && cs_fall) ||
                      ((state_q == ACTIVE) && shift_edge && wb_pending_q);

   // Datapath: shifting, word completion, abort, tx buffer handshake.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      rx_shift_d   = rx_shift_q;
      tx_shift_d   = tx_shift_q;
      tx_buf_d     = tx_buf_q;
      rx_data_d    = rx_data_q;
      bit_cnt_d    = bit_cnt_q;
      tx_ready_d   = tx_ready_q;
      rx_valid_d   = 1'b0;
      underrun_d   = 1'b0;
      wb_pending_d = wb_pending_q;

      if (state_q == ACTIVE && cs_rise) begin
         // Abort: drop any partial word; the tx buffer is left untouched.
         rx_shift_d   = '0;
         bit_cnt_d    = '0;
         wb_pending_d = 1'b0;
      end else if (state_q == ACTIVE) begin
         if (bit_cnt_q == CNT_W'(DATA_W)) begin
            rx_data_d    = rx_shift_q;
            rx_valid_d   = 1'b1;
            bit_cnt_d    = '0;
            wb_pending_d = 1'b1;
         end else if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 1'b1;
         end
         if (shift_edge) begin
            if (wb_pending_q) wb_pending_d = 1'b0;
            else              tx_shift_d   = {tx_shift_q[DATA_W-2:0], 1'b0};
         end
      end

      if (word_load) begin
         if (tx_ready_q) begin
            tx_shift_d = '0;
            underrun_d = 1'b1;
         end else begin
            tx_shift_d = tx_buf_q;
         end
         tx_ready_d = 1'b1;
      end

      // Written after the word load so a same-cycle load sees the old buffer
      // and the freshly written word leaves the buffer full.
      if (tx_load && tx_ready_q) begin
         tx_buf_d   = tx_data;
         tx_ready_d = 1'b0;
      end
   end

   // Outputs: miso is driven only during a transaction.
   always_comb begin
      busy = (state_q == ACTIVE);
      miso = busy ? tx_shift_q[DATA_W-1] : 1'b0;
   end

   assign tx_ready    = tx_ready_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = underrun_q;

endmodule : spi_slave_if

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: an SPI master task drives directed
// words, a transaction-level model predicts received words, transmitted words
// and underruns, and a per-cycle compare process checks the DUT against it.
module tb_spi_slave_if;
   import spi_pkg::*;

   localparam int SYNC = 2;
   localparam int HALF = MIN_CLK_RATIO + 1;  // sclk half period in clk cycles

   logic       clk = 1'b0;
   logic       reset, sclk, cs_n, mosi, tx_load;
   logic [7:0] tx_data;
   logic       miso, tx_ready, rx_valid, busy, tx_underrun;
   logic [7:0] rx_data;

   spi_slave_if #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .reset       (reset),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .tx_data     (tx_data),
      .tx_load     (tx_load),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .tx_underrun (tx_underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Transaction-level model state.
   logic [7:0] exp_rx_q[$];
   logic [7:0] model_last_rx;
   logic       model_full;
   logic [7:0] model_buf;
   logic [7:0] exp_tx;
   int         exp_underrun, seen_underrun, seen_rx_valid;
   int         cs_hi_cnt, cs_lo_cnt;
   int         rv0;
   logic [7:0] mi;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // A word is taken from the buffer when it holds one, otherwise zeros go out.
   task automatic model_load();
      if (model_full) begin
         exp_tx     = model_buf;
         model_full = 1'b0;
      end else begin
         exp_tx = 8'h00;
         exp_underrun++;
      end
   endtask

   task automatic tx_push(input logic [7:0] v);
      tx_data = v;
      tx_load = 1'b1;
      if (!model_full) begin
         model_buf  = v;
         model_full = 1'b1;
      end
      tick(1);
      tx_load = 1'b0;
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      model_load();
      tick(SYNC + 4);
   endtask

   task automatic cs_end();
      tick(HALF);
      cs_n = 1'b1;
      tick(SYNC + 4);
   endtask

   // Mode-0 master: mosi set while sclk low, miso sampled at sclk rise.
   task automatic master_word(input logic [7:0] mo, input int nbits, output logic [7:0] got);
      got = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         tick(HALF);
         sclk = 1'b1;
         got  = {got[6:0], miso};
         if (i == 7) exp_rx_q.push_back(mo);
         tick(HALF);
         sclk = 1'b0;
      end
      check("miso_word", got, exp_tx >> (8 - nbits));
      if (nbits == 8) model_load();
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!reset) begin
         cs_hi_cnt = 0;
         cs_lo_cnt = 0;
      end else begin
         if (rx_valid) begin
            seen_rx_valid++;
            check("rx_valid_expected", exp_rx_q.size() > 0, 1);
            if (exp_rx_q.size() > 0) model_last_rx = exp_rx_q.pop_front();
         end
         check("rx_data", rx_data, model_last_rx);
         if (tx_underrun) seen_underrun++;
         if (cs_n) begin cs_hi_cnt++; cs_lo_cnt = 0; end
         else      begin cs_lo_cnt++; cs_hi_cnt = 0; end
         if (cs_hi_cnt > SYNC + 2) begin
            check("idle_busy", busy, 0);
            check("idle_miso", miso, 0);
         end
         if (cs_lo_cnt > SYNC + 2) check("active_busy", busy, 1);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_values();
      check("rst_miso", miso, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_tx_underrun", tx_underrun, 0);
   endtask

   initial begin
      reset = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      tx_load = 1'b0; tx_data = 8'h00;
      model_last_rx = 8'h00; model_full = 1'b0; model_buf = 8'h00; exp_tx = 8'h00;
      exp_underrun = 0; seen_underrun = 0; seen_rx_valid = 0;
      cs_hi_cnt = 0; cs_lo_cnt = 0;

      // Reset, then sclk activity with cs_n high must be ignored.
      tick(2);
      check_reset_values();
      reset = 1'b1;
      tick(2);
      mosi = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(HALF); sclk = 1'b1;
         tick(HALF); sclk = 1'b0;
      end
      tick(4);
      check("idle_no_rx_valid", seen_rx_valid, 0);

      // Single exchange.
      tx_push(8'h3C);
      check("single_tx_ready_full", tx_ready, 0);
      cs_begin();
      check("single_busy", busy, 1);
      check("single_tx_ready_taken", tx_ready, 1);
      rv0 = seen_rx_valid;
      master_word(8'hA5, 8, mi);
      check("single_miso_lit", mi, 8'h3C);
      cs_end();
      check("single_rx_lit", rx_data, 8'hA5);
      check("single_rx_pulses", seen_rx_valid - rv0, 1);
      check("single_tx_ready", tx_ready, 1);

      // Back-to-back words in one chip-select window.
      tx_push(8'h81);
      cs_begin();
      check("b2b_tx_ready", tx_ready, 1);
      tx_push(8'h7E);
      rv0 = seen_rx_valid;
      master_word(8'h12, 8, mi);
      check("b2b_miso0_lit", mi, 8'h81);
      master_word(8'h34, 8, mi);
      check("b2b_miso1_lit", mi, 8'h7E);
      cs_end();
      check("b2b_rx_lit", rx_data, 8'h34);
      check("b2b_rx_pulses", seen_rx_valid - rv0, 2);

      // Underrun: nothing preloaded.
      rv0 = seen_underrun;
      cs_begin();
      check("underrun_at_cs_fall", seen_underrun - rv0, 1);
      master_word(8'hFF, 8, mi);
      check("underrun_miso_lit", mi, 8'h00);
      cs_end();
      check("underrun_rx_lit", rx_data, 8'hFF);

      // Abort after 5 bits, then a full word.
      tx_push(8'h96);
      rv0 = seen_rx_valid;
      cs_begin();
      master_word(8'hC3, 5, mi);
      check("abort_miso_lit", mi, 8'h12);
      cs_end();
      check("abort_no_rx_valid", seen_rx_valid - rv0, 0);
      check("abort_rx_held", rx_data, 8'hFF);
      cs_begin();
      master_word(8'h5A, 8, mi);
      cs_end();
      check("abort_next_rx_lit", rx_data, 8'h5A);

      // Reset in the middle of a word.
      tx_push(8'hE7);
      cs_begin();
      master_word(8'hB0, 3, mi);
      reset = 1'b0;
      #1;
      check_reset_values();
      exp_rx_q.delete();
      model_last_rx = 8'h00;
      model_full    = 1'b0;
      cs_n = 1'b1; sclk = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(3);

      // Second load while the buffer is full is ignored.
      tx_push(8'h11);
      check("ignored_tx_ready", tx_ready, 0);
      tx_push(8'h22);
      cs_begin();
      master_word(8'h66, 8, mi);
      check("ignored_miso_lit", mi, 8'h11);
      cs_end();
      check("ignored_rx_lit", rx_data, 8'h66);

      check("underrun_count", seen_underrun, exp_underrun);
      check("rx_queue_drained", exp_rx_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_spi_slave_if
